// File: rtl/mcdf_pkg.sv
// Shared widths and FSM state encodings for the MCDF output receiver.
package mcdf_pkg;
  localparam int CHID_W  = 2;
  localparam int LEN_W   = 6;
  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_DLY      = 3'd1;
  localparam logic [STATE_W-1:0] ST_GRANT    = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_SOP = 3'd3;
  localparam logic [STATE_W-1:0] ST_RECV     = 3'd4;
  localparam logic [STATE_W-1:0] ST_DRAIN    = 3'd5;
endpackage

// File: rtl/rcv_chan_cnt.sv
// One 16-bit good-packet counter that sticks at all-ones instead of wrapping.
module rcv_chan_cnt (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_inc,
  output logic [15:0] o_cnt
);
  logic [15:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != 16'hFFFF))
      r_cnt <= r_cnt + 16'd1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/fmt_rcv.sv
// Formatter-side receiver: timed grant, burst capture, length check, registered
// forwarding, per-channel good-packet counters and sticky error flags.
module fmt_rcv
  import mcdf_pkg::*;
#(
  parameter int DATA_WIDE = 32,
  parameter int GRANT_DLY = 2,
  parameter int START_TO  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rcv_en,
  input  logic                 i_fmt_req,
  input  logic [1:0]           i_fmt_chid,
  input  logic [5:0]           i_fmt_length,
  input  logic                 i_fmt_start,
  input  logic                 i_fmt_end,
  input  logic [DATA_WIDE-1:0] i_fmt_data,
  input  logic                 i_err_clr,
  output logic                 o_fmt_grant,
  output logic                 o_rcv_valid,
  output logic                 o_rcv_sop,
  output logic                 o_rcv_eop,
  output logic [1:0]           o_rcv_chid,
  output logic [DATA_WIDE-1:0] o_rcv_data,
  output logic [15:0]          o_pkt_cnt0,
  output logic [15:0]          o_pkt_cnt1,
  output logic [15:0]          o_pkt_cnt2,
  output logic [15:0]          o_pkt_cnt3,
  output logic                 o_err_short,
  output logic                 o_err_long,
  output logic                 o_err_to,
  output logic                 o_err_proto
);
  localparam logic [7:0] DLY_LAST = (GRANT_DLY > 0) ? 8'(GRANT_DLY - 1) : 8'd0;
  localparam logic [7:0] TO_LAST  = 8'(START_TO - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [7:0]         r_tmr,  w_tmr_next;
  logic [LEN_W-1:0]   r_wcnt, w_wcnt_next;
  logic [LEN_W-1:0]   r_len,  w_len_next;
  logic [CHID_W-1:0]  r_chid, w_chid_next;
  logic               r_hold, w_hold_next;
  logic [LEN_W-1:0]   w_word;
  logic               w_take, w_fwd, w_sop, w_eop, w_good;
  logic               w_set_short, w_set_long, w_set_to, w_set_proto;

  logic               r_valid, r_sop, r_eop;
  logic [CHID_W-1:0]  r_out_chid;
  logic [DATA_WIDE-1:0] r_data;
  logic               r_err_short, r_err_long, r_err_to, r_err_proto;
  logic [3:0]         w_inc;
  logic [15:0]        w_cnt [4];

  // Ordinal of the word being sampled this cycle; the SOP word is word 1.
  assign w_word = (r_state == ST_WAIT_SOP) ? LEN_W'(1) : r_wcnt + LEN_W'(1);

  always_comb begin
    w_state_next = r_state;
    w_tmr_next   = r_tmr;
    w_wcnt_next  = r_wcnt;
    w_len_next   = r_len;
    w_chid_next  = r_chid;
    w_hold_next  = r_hold;
    w_take       = 1'b0;
    w_fwd        = 1'b0;
    w_sop        = 1'b0;
    w_eop        = 1'b0;
    w_good       = 1'b0;
    w_set_short  = 1'b0;
    w_set_long   = 1'b0;
    w_set_to     = 1'b0;
    w_set_proto  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!i_fmt_req) begin
          w_hold_next = 1'b0;
        end else if (i_rcv_en && !r_hold) begin
          w_chid_next = i_fmt_chid;
          w_len_next  = i_fmt_length;
          w_tmr_next  = '0;
          // A zero-length request is refused until the formatter withdraws it.
          if (i_fmt_length == '0) begin
            w_set_proto = 1'b1;
            w_hold_next = 1'b1;
          end else if (GRANT_DLY == 0) begin
            w_state_next = ST_GRANT;
          end else begin
            w_state_next = ST_DLY;
          end
        end
      end
      ST_DLY: begin
        if (!i_fmt_req) begin
          w_state_next = ST_IDLE;
          w_set_proto  = 1'b1;
        end else if (r_tmr == DLY_LAST) begin
          w_state_next = ST_GRANT;
        end else begin
          w_tmr_next = r_tmr + 8'd1;
        end
      end
      ST_GRANT: begin
        w_state_next = ST_WAIT_SOP;
        w_tmr_next   = '0;
      end
      ST_WAIT_SOP: begin
        if (i_fmt_start) begin
          w_take = 1'b1;
          w_sop  = 1'b1;
        end else if (r_tmr == TO_LAST) begin
          w_state_next = ST_IDLE;
          w_set_to     = 1'b1;
        end else begin
          w_tmr_next = r_tmr + 8'd1;
        end
      end
      ST_RECV: begin
        w_take      = 1'b1;
        w_set_proto = i_fmt_start;
      end
      ST_DRAIN: begin
        w_set_proto = i_fmt_start;
        if (i_fmt_end)
          w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Word-level bookkeeping shared by the SOP word and every RECV word.
    if (w_take) begin
      w_fwd       = 1'b1;
      w_wcnt_next = w_word;
      if (i_fmt_end) begin
        w_eop        = 1'b1;
        w_state_next = ST_IDLE;
        if (w_word == r_len)
          w_good = 1'b1;
        else
          w_set_short = 1'b1;
      end else if (w_word == r_len) begin
        w_eop        = 1'b1;
        w_set_long   = 1'b1;
        w_state_next = ST_DRAIN;
      end else begin
        w_state_next = ST_RECV;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_wcnt  <= '0;
      r_len   <= '0;
      r_chid  <= '0;
      r_hold  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tmr   <= w_tmr_next;
      r_wcnt  <= w_wcnt_next;
      r_len   <= w_len_next;
      r_chid  <= w_chid_next;
      r_hold  <= w_hold_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid     <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_out_chid  <= '0;
      r_data      <= '0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_err_to    <= 1'b0;
      r_err_proto <= 1'b0;
    end else begin
      r_valid <= w_fwd;
      r_sop   <= w_sop;
      r_eop   <= w_eop;
      if (w_fwd) begin
        r_data     <= i_fmt_data;
        r_out_chid <= r_chid;
      end
      // Set wins over a coincident clear.
      r_err_short <= w_set_short | (r_err_short & ~i_err_clr);
      r_err_long  <= w_set_long  | (r_err_long  & ~i_err_clr);
      r_err_to    <= w_set_to    | (r_err_to    & ~i_err_clr);
      r_err_proto <= w_set_proto | (r_err_proto & ~i_err_clr);
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    assign w_inc[gi] = w_good && (r_chid == CHID_W'(gi));
    rcv_chan_cnt u_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (w_inc[gi]),
      .o_cnt   (w_cnt[gi])
    );
  end

  assign o_fmt_grant = (r_state == ST_GRANT);
  assign o_rcv_valid = r_valid;
  assign o_rcv_sop   = r_sop;
  assign o_rcv_eop   = r_eop;
  assign o_rcv_chid  = r_out_chid;
  assign o_rcv_data  = r_data;
  assign o_pkt_cnt0  = w_cnt[0];
  assign o_pkt_cnt1  = w_cnt[1];
  assign o_pkt_cnt2  = w_cnt[2];
  assign o_pkt_cnt3  = w_cnt[3];
  assign o_err_short = r_err_short;
  assign o_err_long  = r_err_long;
  assign o_err_to    = r_err_to;
  assign o_err_proto = r_err_proto;
endmodule

// File: tb/tb_fmt_rcv.sv
// Randomized packet bench for fmt_rcv against a packet-level reference model.
module tb_fmt_rcv;
  localparam int DW  = 32;
  localparam int GD  = 2;
  localparam int STO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rcv_en, fmt_req, fmt_start, fmt_end, err_clr;
  logic [1:0]    fmt_chid;
  logic [5:0]    fmt_length;
  logic [DW-1:0] fmt_data;
  logic          fmt_grant, rcv_valid, rcv_sop, rcv_eop;
  logic [1:0]    rcv_chid;
  logic [DW-1:0] rcv_data;
  logic [15:0]   pkt_cnt0, pkt_cnt1, pkt_cnt2, pkt_cnt3;
  logic          err_short, err_long, err_to, err_proto;

  always #5 clk = ~clk;

  fmt_rcv #(.DATA_WIDE(DW), .GRANT_DLY(GD), .START_TO(STO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rcv_en(rcv_en), .i_fmt_req(fmt_req),
    .i_fmt_chid(fmt_chid), .i_fmt_length(fmt_length), .i_fmt_start(fmt_start),
    .i_fmt_end(fmt_end), .i_fmt_data(fmt_data), .i_err_clr(err_clr),
    .o_fmt_grant(fmt_grant), .o_rcv_valid(rcv_valid), .o_rcv_sop(rcv_sop),
    .o_rcv_eop(rcv_eop), .o_rcv_chid(rcv_chid), .o_rcv_data(rcv_data),
    .o_pkt_cnt0(pkt_cnt0), .o_pkt_cnt1(pkt_cnt1), .o_pkt_cnt2(pkt_cnt2),
    .o_pkt_cnt3(pkt_cnt3), .o_err_short(err_short), .o_err_long(err_long),
    .o_err_to(err_to), .o_err_proto(err_proto)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
    logic [1:0]    ch;
  } word_t;

  word_t got_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    m_cnt[4];
  bit    m_short, m_long, m_to, m_proto;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (rcv_valid) got_q.push_back({rcv_data, rcv_sop, rcv_eop, rcv_chid});

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_short = 0; m_long = 0; m_to = 0; m_proto = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {rcv_valid, rcv_sop, rcv_eop, fmt_grant, rcv_chid,
                          err_short, err_long, err_to, err_proto}, 64'd0);
    check({tag, "_data"}, 64'(rcv_data), 64'd0);
    check({tag, "_cnt"}, {pkt_cnt0, pkt_cnt1, pkt_cnt2, pkt_cnt3}, 64'd0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_err_short"}, 64'(err_short), 64'(m_short));
    check({tag, "_err_long"},  64'(err_long),  64'(m_long));
    check({tag, "_err_to"},    64'(err_to),    64'(m_to));
    check({tag, "_err_proto"}, 64'(err_proto), 64'(m_proto));
    check({tag, "_cnt0"}, 64'(pkt_cnt0), 64'(m_cnt[0]));
    check({tag, "_cnt1"}, 64'(pkt_cnt1), 64'(m_cnt[1]));
    check({tag, "_cnt2"}, 64'(pkt_cnt2), 64'(m_cnt[2]));
    check({tag, "_cnt3"}, 64'(pkt_cnt3), 64'(m_cnt[3]));
  endtask

  task automatic wait_grant(input int exp_lat, output bit ok);
    ok = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (fmt_grant) begin
        check("grant_lat", 64'(c), 64'(exp_lat));
        ok = 1;
        break;
      end
    end
    if (!ok) check("grant_seen", 64'd0, 64'd1);
  endtask

  task automatic clear_err();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    m_short = 0; m_long = 0; m_to = 0; m_proto = 0;
    @(negedge clk);
    check_state("clr");
  endtask

  // nw words are sent with end on the last; nw==0 never starts. Start comes
  // dly cycles after the grant cycle; sop2>0 marks a spurious start on that word.
  task automatic run_pkt(input logic [1:0] ch, input int len, input int nw,
                         input int dly, input int sop2, input int en_hold);
    word_t         exp_q[$];
    bit            ok, tmo;
    int            g;
    logic [DW-1:0] d;
    tmo = (nw == 0) || (dly > STO);
    got_q.delete();
    @(negedge clk);
    fmt_req = 1'b1; fmt_chid = ch; fmt_length = 6'(len);
    if (en_hold > 0) begin
      rcv_en = 1'b0;
      g = 0;
      repeat (en_hold) begin
        @(negedge clk);
        if (fmt_grant) g++;
      end
      check("no_grant_en_low", 64'(g), 64'd0);
      rcv_en = 1'b1;
    end
    wait_grant(GD + 1, ok);
    fmt_req = 1'b0;
    if (!ok) return;
    if (nw > 0) begin
      repeat (dly) @(negedge clk);
      for (int w = 0; w < nw; w++) begin
        if (w > 0) @(negedge clk);
        d = $urandom;
        fmt_data  = d;
        fmt_start = (w == 0) || (w == sop2);
        fmt_end   = (w == nw - 1);
        if (!tmo && w < len)
          exp_q.push_back({d, (w == 0), (w == len - 1) || (w == nw - 1), ch});
      end
      @(negedge clk);
      fmt_start = 1'b0; fmt_end = 1'b0; fmt_data = '0;
    end else begin
      repeat (STO + 2) @(negedge clk);
    end
    if (tmo) m_to = 1;
    else begin
      if (nw == len) begin
        if (m_cnt[ch] < 65535) m_cnt[ch]++;
      end else if (nw < len) m_short = 1;
      else m_long = 1;
      if (sop2 > 0 && sop2 < nw) m_proto = 1;
    end
    repeat (3) @(negedge clk);
    check("word_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("word", 64'(got_q[i]), 64'(exp_q[i]));
    check_state("pkt");
    $display("pkt ch=%0d len=%0d words=%0d dly=%0d sop2=%0d fwd=%0d", ch, len, nw, dly, sop2, got_q.size());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int g, len, nw, dly, sop2;
    rst_n = 1'b0; rcv_en = 1'b1; fmt_req = 1'b0; fmt_start = 1'b0; fmt_end = 1'b0;
    err_clr = 1'b0; fmt_chid = '0; fmt_length = '0; fmt_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_pkt(2'd1, 3, 3, 1, 0, 0);          // good packet
    run_pkt(2'd2, 1, 1, 1, 0, 0);          // single-word packet
    run_pkt(2'd0, 4, 2, 2, 0, 0);          // short
    clear_err();
    run_pkt(2'd3, 2, 5, 1, 0, 0);          // long
    run_pkt(2'd1, 3, 0, 1, 0, 0);          // no start at all
    run_pkt(2'd1, 3, 3, 1, 0, 0);          // recovery after timeout
    clear_err();
    run_pkt(2'd2, 2, 2, STO, 0, 0);        // start on the last allowed cycle
    run_pkt(2'd2, 2, 2, STO + 1, 0, 0);    // one cycle too late
    run_pkt(2'd0, 3, 3, 1, 0, 20);         // rcv_en low for 20 cycles
    run_pkt(2'd3, 4, 4, 1, 2, 0);          // spurious start mid-packet

    // Request withdrawn during the grant delay.
    clear_err();
    @(negedge clk); fmt_req = 1'b1; fmt_chid = 2'd0; fmt_length = 6'd4;
    @(negedge clk); fmt_req = 1'b0;
    g = 0;
    repeat (6) begin @(negedge clk); if (fmt_grant) g++; end
    check("no_grant_req_drop", 64'(g), 64'd0);
    m_proto = 1;
    check_state("req_drop");

    // Zero-length request is never granted.
    clear_err();
    @(negedge clk); fmt_req = 1'b1; fmt_length = 6'd0;
    g = 0;
    repeat (10) begin @(negedge clk); if (fmt_grant) g++; end
    check("no_grant_len0", 64'(g), 64'd0);
    m_proto = 1;
    check_state("len0");
    fmt_req = 1'b0;
    @(negedge clk);
    clear_err();

    for (int i = 0; i < 30; i++) begin
      len  = $urandom_range(1, 8);
      nw   = $urandom_range(1, len + 3);
      dly  = ($urandom_range(0, 7) == 0) ? $urandom_range(STO - 1, STO + 2) : $urandom_range(1, 3);
      sop2 = ($urandom_range(0, 5) == 0) ? $urandom_range(1, nw) : 0;
      run_pkt(2'($urandom_range(0, 3)), len, nw, dly, sop2, 0);
      if ($urandom_range(0, 4) == 0) clear_err();
    end

    // Reset in the middle of a packet.
    @(negedge clk); fmt_req = 1'b1; fmt_chid = 2'd2; fmt_length = 6'd8;
    wait_grant(GD + 1, ok);
    fmt_req = 1'b0;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      fmt_start = (w == 0); fmt_data = $urandom;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_rst");
    fmt_start = 1'b0; fmt_data = '0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_state("after_rst");
    run_pkt(2'd2, 2, 2, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
